// File: rtl/conv_pkg.sv
// Shared widths and arithmetic helpers for the weight-stationary conv PE array.
package conv_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int WGT_W_DEF    = 8;
  localparam int ACC_W_DEF    = 32;
  localparam int MULT_LAT_DEF = 2;
  localparam int PROD_W       = DATA_W_DEF + WGT_W_DEF;
  localparam int MAX_ACC_W    = 64;

  // A signed add overflows when both operands share a sign the result does not.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  // Replace a wrapped sum with the rail matching the operand sign; the caller truncates to acc_w.
  function automatic logic [MAX_ACC_W-1:0] sat_add(input logic [MAX_ACC_W-1:0] sum,
                                                   input logic ovf, input logic a_msb,
                                                   input int unsigned acc_w);
    logic [MAX_ACC_W-1:0] pos_max;
    pos_max = (MAX_ACC_W'(1) << (acc_w - 1)) - MAX_ACC_W'(1);
    if (!ovf) return sum;
    return a_msb ? ~pos_max : pos_max;
  endfunction

endpackage

// File: rtl/conv_pe_ws_if.sv
// Left/upper stream, weight-load and right/lower stream signals of one conv PE.
interface conv_pe_ws_if
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int WGT_W  = WGT_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
);
  logic                     i_vld;
  logic signed [DATA_W-1:0] i_dl;
  logic signed [ACC_W-1:0]  i_au;
  logic                     i_first;
  logic                     i_wld;
  logic signed [WGT_W-1:0]  i_wd;
  logic                     i_wsw;
  logic                     o_vld_r;
  logic signed [DATA_W-1:0] o_dr;
  logic                     o_vld;
  logic signed [ACC_W-1:0]  o_ad;
  logic signed [WGT_W-1:0]  o_w;
  logic                     o_ovf;

  modport master (
    output i_vld, i_dl, i_au, i_first, i_wld, i_wd, i_wsw,
    input  o_vld_r, o_dr, o_vld, o_ad, o_w, o_ovf
  );

  modport slave (
    input  i_vld, i_dl, i_au, i_first, i_wld, i_wd, i_wsw,
    output o_vld_r, o_dr, o_vld, o_ad, o_w, o_ovf
  );
endinterface

// File: rtl/conv_mult_pipe.sv
// Signed DATA_W x WGT_W multiplier with MULT_LAT register stages; a sideband word
// and the valid travel alongside the product.
module conv_mult_pipe
  import conv_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WGT_W    = WGT_W_DEF,
  parameter int SIDE_W   = ACC_W_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_vld,
  input  logic signed [DATA_W-1:0]        i_a,
  input  logic signed [WGT_W-1:0]         i_b,
  input  logic signed [SIDE_W-1:0]        i_side,
  output logic                            o_vld,
  output logic signed [DATA_W+WGT_W-1:0]  o_prod,
  output logic signed [SIDE_W-1:0]        o_side
);

  localparam int MUL_W = DATA_W + WGT_W;

  logic [MULT_LAT-1:0]      vld_d, vld_q;
  logic signed [MUL_W-1:0]  prod_d [MULT_LAT];
  logic signed [MUL_W-1:0]  prod_q [MULT_LAT];
  logic signed [SIDE_W-1:0] side_d [MULT_LAT];
  logic signed [SIDE_W-1:0] side_q [MULT_LAT];

  // Data stages load only behind a valid, so idle cycles leave them untouched.
  always_comb begin
    vld_d     = vld_q;
    vld_d[0]  = i_vld;
    prod_d[0] = i_vld ? MUL_W'(i_a) * MUL_W'(i_b) : prod_q[0];
    side_d[0] = i_vld ? i_side : side_q[0];
    for (int s = 1; s < MULT_LAT; s++) begin
      vld_d[s]  = vld_q[s-1];
      prod_d[s] = vld_q[s-1] ? prod_q[s-1] : prod_q[s];
      side_d[s] = vld_q[s-1] ? side_q[s-1] : side_q[s];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) vld_q <= '0;
    else       vld_q <= vld_d;
  end

  // NOTE: the product/sideband registers are deliberately not reset; the cleared valids
  // already mark their contents as dead, and leaving them unreset keeps the datapath lean.
  always_ff @(posedge i_clk) begin
    prod_q <= prod_d;
    side_q <= side_d;
  end

  assign o_vld  = vld_q[MULT_LAT-1];
  assign o_prod = prod_q[MULT_LAT-1];
  assign o_side = side_q[MULT_LAT-1];

endmodule

// File: rtl/conv_pe_ws.sv
// Weight-stationary conv PE with double-buffered weight: o_ad = i_dl*w + i_au, MULT_LAT+1 cycles.
// Define CONV_PE_SAT_EN to saturate o_ad on overflow instead of wrapping.
module conv_pe_ws
  import conv_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WGT_W    = WGT_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst,
  conv_pe_ws_if.slave  bus
);

  localparam int MUL_W = DATA_W + WGT_W;

  logic                     vld_r_d, vld_r_q;
  logic signed [DATA_W-1:0] dr_d, dr_q;
  logic signed [WGT_W-1:0]  shadow_d, shadow_q;
  logic signed [WGT_W-1:0]  active_d, active_q;
  logic signed [ACC_W-1:0]  ad_d, ad_q;
  logic                     vld_d, vld_q;
  logic                     ovf_d, ovf_q;

  logic signed [ACC_W-1:0]  au_in;
  logic                     m_vld;
  logic signed [MUL_W-1:0]  m_prod;
  logic signed [ACC_W-1:0]  m_side;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  sum;
  logic                     sum_ovf;

  assign au_in = bus.i_first ? '0 : bus.i_au;

  conv_mult_pipe #(
    .DATA_W   (DATA_W),
    .WGT_W    (WGT_W),
    .SIDE_W   (ACC_W),
    .MULT_LAT (MULT_LAT)
  ) u_mult (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_vld  (bus.i_vld),
    .i_a    (bus.i_dl),
    .i_b    (active_q),
    .i_side (au_in),
    .o_vld  (m_vld),
    .o_prod (m_prod),
    .o_side (m_side)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    vld_r_d  = bus.i_vld;
    dr_d     = bus.i_vld ? bus.i_dl : dr_q;
    // Same-cycle load and swap: active takes the old shadow, shadow takes the new word.
    shadow_d = bus.i_wld ? bus.i_wd : shadow_q;
    active_d = bus.i_wsw ? shadow_q : active_q;

    prod_ext = ACC_W'(m_prod);
    sum      = prod_ext + m_side;
    sum_ovf  = add_ovf(prod_ext[ACC_W-1], m_side[ACC_W-1], sum[ACC_W-1]);

    vld_d = m_vld;
    ovf_d = ovf_q | (m_vld & sum_ovf);
    ad_d  = ad_q;
    if (m_vld) begin
`ifdef CONV_PE_SAT_EN
      ad_d = ACC_W'(sat_add(MAX_ACC_W'(sum), sum_ovf, prod_ext[ACC_W-1], ACC_W));
`else
      ad_d = sum;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_r_q  <= 1'b0;
      dr_q     <= '0;
      shadow_q <= '0;
      active_q <= '0;
      ad_q     <= '0;
      vld_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      vld_r_q  <= vld_r_d;
      dr_q     <= dr_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      ad_q     <= ad_d;
      vld_q    <= vld_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.o_vld_r = vld_r_q;
  assign bus.o_dr    = dr_q;
  assign bus.o_vld   = vld_q;
  assign bus.o_ad    = ad_q;
  assign bus.o_w     = active_q;
  assign bus.o_ovf   = ovf_q;

endmodule
